vga_fb_writer: RTL and testbench

Frame-buffer write port for the VGA memory interface. It accepts a pixel stream over a valid/ready handshake and packs `PXL_PER_ROW` pixels into one BRAM word. It then writes each word to port B of the dual-port frame-buffer BRAM while the display path reads port A. Address order and bit packing are the exact inverse of the display read path, so a frame written here displays unchanged.

---
 rtl/vga_fb_writer_pkg.sv | 21 ++
 rtl/fb_pxl_packer.sv | 63 ++++++
 rtl/vga_fb_writer.sv | 105 ++++++++++
 tb/tb_vga_fb_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_writer_pkg.sv
// Shared types and default geometry for the frame-buffer write port.
// Widths here match the display read path.
package vga_fb_writer_pkg;

  localparam int PXL_WIDTH      = 1;
  localparam int PXL_PER_ROW    = 8;
  localparam int MEM_DEPTH      = 38400;
  localparam int MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH;
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH);

  typedef logic [PXL_WIDTH-1:0]      pixel_t;
  typedef logic [MEM_WIDTH-1:0]      mem_word_t;
  typedef logic [MEM_ADDR_WIDTH-1:0] mem_addr_t;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    FILL_S  = 2'd1,
    WRITE_S = 2'd2
  } fb_wr_state_t;

endpackage

// File: rtl/fb_pxl_packer.sv
// Packs pixels into a BRAM word, slot 0 in the LSBs.
// word_o is the word including the pixel being loaded this cycle.
module fb_pxl_packer
  import vga_fb_writer_pkg::*;
#(
  parameter int PXL_WIDTH   = vga_fb_writer_pkg::PXL_WIDTH,
  parameter int PXL_PER_ROW = vga_fb_writer_pkg::PXL_PER_ROW,
  localparam int MW = PXL_WIDTH * PXL_PER_ROW
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  input  logic                 sof_i,
  input  logic [PXL_WIDTH-1:0] pxl_i,
  output logic [MW-1:0]        word_o,
  output logic                 full_o
);

  localparam int SW =
    (PXL_PER_ROW > 1) ? $clog2(PXL_PER_ROW) : 1;
  localparam logic [SW-1:0] LAST = SW'(PXL_PER_ROW - 1);

  logic [SW-1:0] slot_q, slot_d, slot_eff;
  logic [MW-1:0] word_q, word_d, word_nxt;
  logic          last;

  always_comb begin
    // SOF restarts the word: slot 0 of an otherwise empty word
    slot_eff = sof_i ? '0 : slot_q;
    word_nxt = sof_i ? '0 : word_q;
    word_nxt[slot_eff*PXL_WIDTH +: PXL_WIDTH] = pxl_i;
    last     = (slot_eff == LAST);
    slot_d   = slot_q;
    word_d   = word_q;
    if (clr_i) begin
      slot_d = '0;
      word_d = '0;
    end else if (load_i) begin
      if (last) begin
        slot_d = '0;
        word_d = '0;
      end else begin
        slot_d = slot_eff + 1'b1;
        word_d = word_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slot_q <= '0;
      word_q <= '0;
    end else begin
      slot_q <= slot_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_nxt;
  assign full_o = load_i && last;

endmodule

// File: rtl/vga_fb_writer.sv
// Frame-buffer write port: pixel stream in, packed words to BRAM port B.
// Writes yield to a same-address display read and retry next cycle.
module vga_fb_writer
  import vga_fb_writer_pkg::*;
#(
  parameter int PXL_WIDTH   = vga_fb_writer_pkg::PXL_WIDTH,
  parameter int PXL_PER_ROW = vga_fb_writer_pkg::PXL_PER_ROW,
  parameter int MEM_DEPTH   = vga_fb_writer_pkg::MEM_DEPTH,
  localparam int MEM_WIDTH      = PXL_PER_ROW * PXL_WIDTH,
  localparam int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      pxl_valid_i,
  input  logic                      pxl_sof_i,
  input  logic [PXL_WIDTH-1:0]      pxl_i,
  output logic                      pxl_ready_o,
  input  logic                      rd_en_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_addr_i,
  output logic                      enb_o,
  output logic                      web_o,
  output logic [MEM_ADDR_WIDTH-1:0] addrb_o,
  output logic [MEM_WIDTH-1:0]      dinb_o,
  output logic                      frame_done_o
);

  localparam int AW = MEM_ADDR_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

  fb_wr_state_t         state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [MEM_WIDTH-1:0] dinb_q, dinb_d;
  logic                 done_q, done_d;
  logic                 accept, collide, wr;
  logic                 word_full;
  logic [MEM_WIDTH-1:0] word_nxt;

  assign pxl_ready_o = (state_q == FILL_S);
  assign accept      = pxl_valid_i && pxl_ready_o;
  assign collide     = rd_en_i && (rd_addr_i == addr_q);
  assign wr          = (state_q == WRITE_S) && !collide;

  fb_pxl_packer #(
    .PXL_WIDTH   (PXL_WIDTH),
    .PXL_PER_ROW (PXL_PER_ROW)
  ) u_packer (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_q == IDLE_S),
    .load_i (accept),
    .sof_i  (pxl_sof_i),
    .pxl_i  (pxl_i),
    .word_o (word_nxt),
    .full_o (word_full)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dinb_d  = dinb_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE_S: state_d = FILL_S;
      FILL_S: begin
        if (accept) begin
          if (pxl_sof_i) addr_d = '0;
          if (word_full) begin
            dinb_d  = word_nxt;
            state_d = WRITE_S;
          end
        end
      end
      WRITE_S: begin
        if (wr) begin
          addr_d  = (addr_q == LAST_ADDR) ? '0
                  : addr_q + 1'b1;
          done_d  = (addr_q == LAST_ADDR);
          state_d = FILL_S;
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE_S;
      addr_q  <= '0;
      dinb_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dinb_q  <= dinb_d;
      done_q  <= done_d;
    end
  end

  assign enb_o        = wr;
  assign web_o        = wr;
  assign addrb_o      = addr_q;
  assign dinb_o       = dinb_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: default geometry plus a
// 4-word frame instance for wrap and frame_done.
module tb_vga_fb_writer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pxl_valid = 1'b0;
  logic        pxl_sof = 1'b0;
  logic [0:0]  pxl = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_addr = '0;
  logic [1:0]  rd_addr4;

  logic        ready, enb, web, done;
  logic [15:0] addrb;
  logic [7:0]  dinb;
  logic        ready4, enb4, web4, done4;
  logic [1:0]  addrb4;
  logic [7:0]  dinb4;

  int nvec = 0;
  int errs = 0;
  int cyc  = 0;

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  logic [1:0]  wa4[$];
  logic [7:0]  wd4[$];
  int          wc4[$];
  int          dc4[$];

  assign rd_addr4 = rd_addr[1:0];

  vga_fb_writer dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .pxl_valid_i  (pxl_valid),
    .pxl_sof_i    (pxl_sof),
    .pxl_i        (pxl),
    .pxl_ready_o  (ready),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .enb_o        (enb),
    .web_o        (web),
    .addrb_o      (addrb),
    .dinb_o       (dinb),
    .frame_done_o (done)
  );

  vga_fb_writer #(.MEM_DEPTH(4)) dut4 (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .pxl_valid_i  (pxl_valid),
    .pxl_sof_i    (pxl_sof),
    .pxl_i        (pxl),
    .pxl_ready_o  (ready4),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr4),
    .enb_o        (enb4),
    .web_o        (web4),
    .addrb_o      (addrb4),
    .dinb_o       (dinb4),
    .frame_done_o (done4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (web) begin
      wa.push_back(addrb);
      wd.push_back(dinb);
      wc.push_back(cyc);
    end
    if (web4) begin
      wa4.push_back(addrb4);
      wd4.push_back(dinb4);
      wc4.push_back(cyc);
    end
    if (done4) dc4.push_back(cyc);
  end

  task automatic clear_logs();
    wa.delete(); wd.delete(); wc.delete();
    wa4.delete(); wd4.delete(); wc4.delete();
    dc4.delete();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    pxl_valid = 1'b0;
    pxl_sof = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic push(input logic p, input logic s);
    int guard;
    guard = 0;
    pxl_valid = 1'b1;
    pxl = p;
    pxl_sof = s;
    while (!ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      nvec++; errs++;
      $display("FAIL push_timeout ready stuck low");
    end
    @(posedge clk); #1;
    pxl_valid = 1'b0;
    pxl_sof = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    nvec++;
    if ({ready, enb, web, done} !== 4'b0) begin
      errs++;
      $display("FAIL rst_ctl got %b want 0000",
               {ready, enb, web, done});
    end
    nvec++;
    if (addrb !== 16'h0 || dinb !== 8'h0) begin
      errs++;
      $display("FAIL rst_data got %h/%h want 0/0", addrb, dinb);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    nvec++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_idle_ready got %b want 0", ready);
    end
    @(posedge clk); #1;
    nvec++;
    if (ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_fill_ready got %b want 1", ready);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] pat;
    do_reset();
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) push(pat[i], i == 0);
    nvec++;
    if (web !== 1'b1 || enb !== 1'b1) begin
      errs++;
      $display("FAIL sw_web got %b%b want 11", web, enb);
    end
    nvec++;
    if (addrb !== 16'd0 || dinb !== 8'h8D) begin
      errs++;
      $display("FAIL sw_word got %h/%h want 0/8d", addrb, dinb);
    end
    nvec++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL sw_ready_wr got %b want 0", ready);
    end
    @(posedge clk); #1;
    nvec++;
    if (web !== 1'b0 || ready !== 1'b1) begin
      errs++;
      $display("FAIL sw_after got web %b rdy %b want 0 1",
               web, ready);
    end
    nvec++;
    if (addrb !== 16'd1) begin
      errs++;
      $display("FAIL sw_next_addr got %0d want 1", addrb);
    end
    nvec++;
    if (wa.size() !== 1) begin
      errs++;
      $display("FAIL sw_nwrites got %0d want 1", wa.size());
    end
  endtask

  task automatic test_collision();
    logic [7:0] pat;
    do_reset();
    pat = 8'h96;
    for (int i = 0; i < 8; i++) push(pat[i], i == 0);
    rd_en = 1'b1;
    rd_addr = 16'd0;
    for (int c = 0; c < 3; c++) begin
      #1;
      nvec++;
      if (web !== 1'b0 || enb !== 1'b0 || ready !== 1'b0) begin
        errs++;
        $display("FAIL col_stall%0d got web %b enb %b rdy %b",
                 c, web, enb, ready);
      end
      nvec++;
      if (dinb !== 8'h96 || addrb !== 16'd0) begin
        errs++;
        $display("FAIL col_hold%0d got %h/%h want 0/96",
                 c, addrb, dinb);
      end
      @(posedge clk); #1;
    end
    rd_addr = 16'd1;
    #1;
    nvec++;
    if (web !== 1'b1 || dinb !== 8'h96) begin
      errs++;
      $display("FAIL col_retry got web %b din %h want 1 96",
               web, dinb);
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
    nvec++;
    if (wa.size() !== 1 || wa[0] !== 16'd0 || wd[0] !== 8'h96) begin
      errs++;
      $display("FAIL col_log got n=%0d a=%h d=%h want 1 0 96",
               wa.size(), wa[0], wd[0]);
    end
  endtask

  task automatic test_sof_mid();
    logic [7:0] pat;
    do_reset();
    for (int i = 0; i < 8; i++) push(1'b0, i == 0);
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 3; i++) push(1'b1, 1'b0);
    pat = 8'h85;
    for (int i = 0; i < 8; i++) push(pat[i], i == 0);
    @(posedge clk); #1;
    nvec++;
    if (wa.size() !== 1) begin
      errs++;
      $display("FAIL sof_nwrites got %0d want 1", wa.size());
    end
    nvec++;
    if (wa[0] !== 16'd0 || wd[0] !== 8'h85) begin
      errs++;
      $display("FAIL sof_word got %h/%h want 0/85", wa[0], wd[0]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_w;
    logic [1:0] exp_a;
    do_reset();
    for (int i = 0; i < 40; i++) push(1'((i % 3) == 0), i == 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    nvec++;
    if (wa4.size() !== 5) begin
      errs++;
      $display("FAIL wrap_nwrites got %0d want 5", wa4.size());
    end
    for (int w = 0; w < 5; w++) begin
      exp_a = 2'(w % 4);
      for (int k = 0; k < 8; k++)
        exp_w[k] = ((8 * w + k) % 3) == 0;
      nvec++;
      if (wa4[w] !== exp_a || wd4[w] !== exp_w) begin
        errs++;
        $display("FAIL wrap_w%0d got %h/%h want %h/%h",
                 w, wa4[w], wd4[w], exp_a, exp_w);
      end
    end
    nvec++;
    if (dc4.size() !== 1) begin
      errs++;
      $display("FAIL wrap_done_cnt got %0d want 1", dc4.size());
    end
    nvec++;
    if (dc4[0] !== wc4[3] + 1) begin
      errs++;
      $display("FAIL wrap_done_cyc got %0d want %0d",
               dc4[0], wc4[3] + 1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) push(1'b1, i == 0);
    rstn = 1'b0;
    #1;
    nvec++;
    if (web !== 1'b0 || enb !== 1'b0 || ready !== 1'b0) begin
      errs++;
      $display("FAIL rm_ctl got web %b enb %b rdy %b want 000",
               web, enb, ready);
    end
    nvec++;
    if (addrb !== 16'd0 || dinb !== 8'h0) begin
      errs++;
      $display("FAIL rm_data got %h/%h want 0/0", addrb, dinb);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    nvec++;
    if (ready !== 1'b0) begin
      errs++;
      $display("FAIL rm_idle got rdy %b want 0", ready);
    end
    @(posedge clk); #1;
    nvec++;
    if (ready !== 1'b1 || addrb !== 16'd0) begin
      errs++;
      $display("FAIL rm_release got rdy %b addr %h want 1 0",
               ready, addrb);
    end
    nvec++;
    if (wa.size() !== 0) begin
      errs++;
      $display("FAIL rm_nwrites got %0d want 0", wa.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 16; i++) push(1'(i[1]), i == 0);
    nvec++;
    if (cyc - c0 !== 17) begin
      errs++;
      $display("FAIL b2b_accept got %0d cycles want 17", cyc - c0);
    end
    @(posedge clk); #1;
    nvec++;
    if (wa.size() !== 2 || wa[0] !== 16'd0 || wa[1] !== 16'd1) begin
      errs++;
      $display("FAIL b2b_addrs got n=%0d %h %h want 2 0 1",
               wa.size(), wa[0], wa[1]);
    end
    nvec++;
    if (wd[0] !== 8'hCC || wd[1] !== 8'hCC) begin
      errs++;
      $display("FAIL b2b_data got %h %h want cc cc", wd[0], wd[1]);
    end
    nvec++;
    if (wc[1] + 1 - c0 !== 18) begin
      errs++;
      $display("FAIL b2b_total got %0d cycles want 18",
               wc[1] + 1 - c0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_collision();
    test_sof_mid();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
